// File: rtl/mem_dump_tx_pkg.sv
// Shared definitions for the memory dump transmitter and its loader-side peer.
//   FRAME_SYNC : first byte of every dump frame
//   HDR_LEN    : header bytes (sync, 3 address bytes, 2 length bytes)
//   state_e    : dump FSM state encoding
package mem_dump_tx_pkg;

  localparam logic [7:0] FRAME_SYNC = 8'hA5;
  localparam int         HDR_LEN    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_WAIT,
    S_SEND,
    S_SUM,
    S_FLUSH
  } state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first, idle high.
//   clk, reset : clock, async active-high reset
//   load       : accept data when ready=1
//   data[7:0]  : byte to send
//   ready      : idle, or in the final cycle of a stop bit (allows gapless bytes)
//   tx         : serial output
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int              BW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]   BAUD_TC = BW'(CLKS_PER_BIT - 1);

  logic          active_q;
  logic [3:0]    bit_q;
  logic [BW-1:0] baud_q;
  logic [9:0]    sh_q;

  // Ones shift in from the top so the line rests high once the stop bit is out.
  assign tx    = sh_q[0];
  assign ready = !active_q || (bit_q == 4'd0 && baud_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      baud_q   <= '0;
      sh_q     <= '1;
    end else if (load && ready) begin
      sh_q     <= {1'b1, data, 1'b0};
      bit_q    <= 4'd9;
      baud_q   <= BAUD_TC;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (baud_q != '0) begin
        baud_q <= baud_q - BW'(1);
      end else if (bit_q == 4'd0) begin
        active_q <= 1'b0;
      end else begin
        sh_q   <= {1'b1, sh_q[9:1]};
        bit_q  <= bit_q - 4'd1;
        baud_q <= BAUD_TC;
      end
    end
  end

endmodule

// File: rtl/mem_dump_tx.sv
// Reads a span of external memory and sends it to the host as one UART frame:
// A5, adr[7:0], adr[15:8], adr[20:16], len[7:0], len[15:8], data..., checksum.
//   clk, reset     : clock, async active-high reset
//   start          : request, accepted only while idle
//   start_adr, len : span captured on accepted start
//   cts            : host ready (async, synchronised here), gates each byte start
//   adr, read, din : external memory read port
//   tx             : UART output
//   busy, done     : frame in progress / 1-cycle end-of-frame pulse
//
// state   | meaning
// S_IDLE  | waiting for start
// S_HDR   | sending the 6 header bytes
// S_RD    | first read cycle
// S_WAIT  | remaining read cycles, din captured on the last one
// S_SEND  | hand data byte to shifter, advance address/count/checksum
// S_SUM   | hand checksum to shifter
// S_FLUSH | wait for checksum stop bit, then pulse done
module mem_dump_tx
  import mem_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int READ_WAIT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [20:0] start_adr,
  input  logic [15:0] len,
  input  logic        cts,
  output logic [20:0] adr,
  output logic        read,
  input  logic [7:0]  din,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int            WW      = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_TC = WW'(READ_WAIT - 1);

  state_e        state_q, state_d;
  logic [20:0]   adr_q, adr_d;
  logic [15:0]   rem_q, rem_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    byte_q, byte_d;
  logic [2:0]    hcnt_q, hcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          done_q, done_d;
  logic          cts_meta_q, cts_s_q;

  logic          tx_ready, load, can_send;
  logic [7:0]    ld_data, hdr_byte;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .data  (ld_data),
    .ready (tx_ready),
    .tx    (tx)
  );

  assign adr      = adr_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign can_send = tx_ready && cts_s_q;

  // Header reads adr_q/rem_q directly; both stay at their captured values until data starts.
  always_comb begin
    hdr_byte = FRAME_SYNC;
    case (hcnt_q)
      3'd1:    hdr_byte = adr_q[7:0];
      3'd2:    hdr_byte = adr_q[15:8];
      3'd3:    hdr_byte = {3'b000, adr_q[20:16]};
      3'd4:    hdr_byte = rem_q[7:0];
      3'd5:    hdr_byte = rem_q[15:8];
      default: hdr_byte = FRAME_SYNC;
    endcase
  end

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    sum_d   = sum_q;
    byte_d  = byte_q;
    hcnt_d  = hcnt_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    load    = 1'b0;
    ld_data = byte_q;
    read    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          adr_d   = start_adr;
          rem_d   = len;
          sum_d   = 8'h00;
          hcnt_d  = 3'd0;
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        ld_data = hdr_byte;
        if (can_send) begin
          load = 1'b1;
          if (hcnt_q == 3'(HDR_LEN - 1)) begin
            wcnt_d  = WAIT_TC;
            state_d = (rem_q == 16'd0) ? S_SUM : S_RD;
          end else begin
            hcnt_d = hcnt_q + 3'd1;
          end
        end
      end
      S_RD, S_WAIT: begin
        read = 1'b1;
        if (wcnt_q == '0) begin
          byte_d  = din;
          state_d = S_SEND;
        end else begin
          wcnt_d  = wcnt_q - WW'(1);
          state_d = S_WAIT;
        end
      end
      S_SEND: begin
        ld_data = byte_q;
        if (can_send) begin
          load    = 1'b1;
          adr_d   = adr_q + 21'd1;
          rem_d   = rem_q - 16'd1;
          sum_d   = sum_q + byte_q;
          wcnt_d  = WAIT_TC;
          state_d = (rem_q == 16'd1) ? S_SUM : S_RD;
        end
      end
      S_SUM: begin
        ld_data = sum_q;
        if (can_send) begin
          load    = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // ready rises in the last stop-bit cycle, so done lands on the first idle cycle.
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      adr_q      <= 21'd0;
      rem_q      <= 16'd0;
      sum_q      <= 8'h00;
      byte_q     <= 8'h00;
      hcnt_q     <= 3'd0;
      wcnt_q     <= '0;
      done_q     <= 1'b0;
      cts_meta_q <= 1'b0;
      cts_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      rem_q      <= rem_d;
      sum_q      <= sum_d;
      byte_q     <= byte_d;
      hcnt_q     <= hcnt_d;
      wcnt_q     <= wcnt_d;
      done_q     <= done_d;
      cts_meta_q <= cts;
      cts_s_q    <= cts_meta_q;
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
module tb_mem_dump_tx;

  localparam int CPB = 16;
  localparam int RW  = 2;

  logic        clk = 1'b0;
  logic        reset, start, cts, read, tx, busy, done;
  logic [20:0] start_adr, adr;
  logic [15:0] len;
  logic [7:0]  din;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rd_run = 0;

  logic [7:0] mem [16];

  logic [7:0]  exp_q[$];
  logic [20:0] exp_rd[$];
  logic [7:0]  rx_q[$];
  bit          rx_ok[$];
  int          rx_start[$];
  int          rx_end[$];
  logic [20:0] rd_q[$];
  int          rd_len[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_run <= read ? rd_run + 1 : 0;
  end

  // Memory only drives valid data in the final cycle of a read pulse.
  assign din = (read && rd_run == RW - 1) ? mem[adr[3:0]] : 8'h5A;

  mem_dump_tx #(.CLKS_PER_BIT(CPB), .READ_WAIT(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .start_adr (start_adr),
    .len       (len),
    .cts       (cts),
    .adr       (adr),
    .read      (read),
    .din       (din),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  // UART receiver: every cycle of each bit must match the bit's first cycle.
  initial begin
    logic [9:0] bits;
    bit         ok;
    int         st;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        st = cyc;
        bits = '0;
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) @(negedge clk);
          if (i % CPB == 0) bits[i / CPB] = tx;
          else if (tx !== bits[i / CPB]) ok = 1'b0;
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
        rx_q.push_back(bits[8:1]);
        rx_ok.push_back(ok);
        rx_start.push_back(st);
        rx_end.push_back(cyc);
      end
    end
  end

  // Read-pulse monitor: records address and length of each read pulse.
  initial begin
    int          run;
    bit          stable;
    logic [20:0] radr;
    run = 0; stable = 1'b1; radr = '0;
    forever begin
      @(negedge clk);
      if (read === 1'b1) begin
        if (run == 0) radr = adr;
        else if (adr !== radr) stable = 1'b0;
        run++;
      end else if (run > 0) begin
        rd_q.push_back(radr);
        rd_len.push_back(stable ? run : -1);
        run = 0;
        stable = 1'b1;
      end
    end
  end

  task automatic clear_queues();
    exp_q.delete(); exp_rd.delete(); rx_q.delete(); rx_ok.delete();
    rx_start.delete(); rx_end.delete(); rd_q.delete(); rd_len.delete();
  endtask

  task automatic push_frame(input logic [20:0] a, input logic [15:0] n);
    logic [7:0]  sum;
    logic [20:0] ra;
    sum = 8'h00;
    exp_q.push_back(8'hA5);
    exp_q.push_back(a[7:0]);
    exp_q.push_back(a[15:8]);
    exp_q.push_back({3'b000, a[20:16]});
    exp_q.push_back(n[7:0]);
    exp_q.push_back(n[15:8]);
    ra = a;
    for (int i = 0; i < int'(n); i++) begin
      exp_rd.push_back(ra);
      exp_q.push_back(mem[ra[3:0]]);
      sum = sum + mem[ra[3:0]];
      ra = ra + 21'd1;
    end
    exp_q.push_back(sum);
  endtask

  task automatic run_frame(input string name, input logic [20:0] a, input logic [15:0] n,
                           input int extra_at, input bit gap);
    int          t0, done_cyc, gap_left, gap_state, first_st, last_end, nexp, idx;
    bit          seen;
    logic [7:0]  e, r;
    logic [20:0] ea;
    push_frame(a, n);
    nexp = exp_q.size();
    @(negedge clk);
    start = 1'b1; start_adr = a; len = n; t0 = cyc;
    @(negedge clk);
    start = 1'b0; start_adr = 21'h0AAAAA; len = 16'h1234;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    seen = 1'b0; done_cyc = 0; gap_left = 0; gap_state = 0;
    for (int i = 0; i < 40 * 10 * CPB && !seen; i++) begin
      start = (extra_at > 0 && i == extra_at) ? 1'b1 : 1'b0;
      if (gap && gap_state == 0 && rx_q.size() == 6) begin
        cts = 1'b0; gap_left = 3 * 10 * CPB; gap_state = 1;
      end else if (gap_state == 1) begin
        gap_left--;
        if (gap_left == 0) begin cts = 1'b1; gap_state = 2; end
      end
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
        end
      end
    end
    start = 1'b0; cts = 1'b1;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s done_timeout: got no done expected done pulse", name);
    end else begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL %s done_width: got %b expected 0", name, done);
      end
    end
    checks++;
    if (rx_q.size() != nexp) begin
      errors++; $display("FAIL %s byte_count: got %0d expected %0d", name, rx_q.size(), nexp);
    end
    if (rx_q.size() > 0) begin
      first_st = rx_start[0];
      last_end = rx_end[rx_end.size() - 1];
      checks++;
      if (first_st - t0 > 3) begin
        errors++; $display("FAIL %s first_start_latency: got %0d expected <=3", name, first_st - t0);
      end
      if (seen) begin
        checks++;
        if (done_cyc != last_end + 1) begin
          errors++; $display("FAIL %s done_timing: got %0d expected %0d", name, done_cyc, last_end + 1);
        end
      end
      if (gap && rx_q.size() > 7) begin
        checks++;
        if (rx_start[7] - rx_end[6] <= 10 * CPB) begin
          errors++; $display("FAIL %s cts_gap: got %0d expected >%0d", name, rx_start[7] - rx_end[6], 10 * CPB);
        end
      end
    end
    idx = 0;
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checks++;
      if (r !== e) begin
        errors++; $display("FAIL %s byte%0d: got %02h expected %02h", name, idx, r, e);
      end
      checks++;
      if (rx_ok.pop_front() !== 1'b1) begin
        errors++; $display("FAIL %s bit_width%0d: got bad framing expected %0d-cycle bits", name, idx, CPB);
      end
      idx++;
    end
    checks++;
    if (rd_q.size() != exp_rd.size()) begin
      errors++; $display("FAIL %s read_count: got %0d expected %0d", name, rd_q.size(), exp_rd.size());
    end
    while (exp_rd.size() > 0 && rd_q.size() > 0) begin
      ea = exp_rd.pop_front();
      checks++;
      if (rd_q.pop_front() !== ea) begin
        errors++; $display("FAIL %s read_adr: expected %06h", name, ea);
      end
      checks++;
      if (rd_len.pop_front() != RW) begin
        errors++; $display("FAIL %s read_pulse: expected %0d stable cycles", name, RW);
      end
    end
    clear_queues();
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL %s tx: got %b expected 1", name, tx); end
    checks++;
    if (read !== 1'b0) begin errors++; $display("FAIL %s read: got %b expected 0", name, read); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", name, busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done: got %b expected 0", name, done); end
    checks++;
    if (adr !== 21'd0) begin errors++; $display("FAIL %s adr: got %06h expected 000000", name, adr); end
  endtask

  task automatic test_reset();
    #1;
    check_idle("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; start_adr = 21'h012345; len = 16'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (7 * 10 * CPB) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_idle("reset_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    clear_queues();
  endtask

  task automatic test_basic();
    run_frame("basic", 21'h012345, 16'd2, 0, 1'b0);
  endtask

  task automatic test_len_zero();
    run_frame("len_zero", 21'h000100, 16'd0, 0, 1'b0);
  endtask

  task automatic test_adr_wrap();
    run_frame("adr_wrap", 21'h1FFFFF, 16'd2, 0, 1'b0);
  endtask

  task automatic test_cts_gap();
    run_frame("cts_gap", 21'h012345, 16'd3, 0, 1'b1);
  endtask

  task automatic test_start_busy();
    run_frame("start_busy", 21'h012345, 16'd2, 200, 1'b0);
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_q.size() != 0) begin
      errors++; $display("FAIL start_busy_after: got busy=%b bytes=%0d expected idle", busy, rx_q.size());
    end
    clear_queues();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cts = 1'b1; start_adr = '0; len = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h40 + 8'(i);
    mem[5]  = 8'h10;
    mem[6]  = 8'h20;
    mem[15] = 8'hC3;
    mem[0]  = 8'h3C;
    test_reset();
    test_basic();
    test_len_zero();
    test_adr_wrap();
    test_cts_gap();
    test_start_busy();
    test_reset_mid();
    test_basic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
